// File: rtl/im_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package im_pkg;

    localparam int WORD_W         = 17;
    localparam int OP_W           = 4;
    localparam int REG_W          = 3;
    localparam int IMM_W          = 7;
    localparam int BYTES_PER_WORD = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_B0,
        S_B1,
        S_B2,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/im_loader.sv
// Byte-stream program loader writing 17-bit words into the instruction RAM.
// Optional trailing XOR checksum byte enabled by `define IM_LOADER_CHECKSUM_EN.
module im_loader
    import im_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [WORD_W-1:0] wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int CAP = 1 << ADDR_W;

    // The word layout is hard-wired to three bytes: 1 + 8 + 8 bits.
    if (WORD_W != im_pkg::WORD_W || OP_W + 2 * REG_W + IMM_W != im_pkg::WORD_W
        || BYTES_PER_WORD != 3) begin : g_bad_word
        $error("im_loader: WORD_W must be 17");
    end
    // The header byte must be able to express the full capacity.
    if (ADDR_W < 1 || ADDR_W > 7) begin : g_bad_addr
        $error("im_loader: ADDR_W must be in 1..7");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic                hi_q, hi_d;
    logic [7:0]          mid_q, mid_d;
    logic                rx_ready_q, rx_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                acc;
    logic [ADDR_W:0]     cnt_inc;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    assign acc     = rx_valid && rx_ready_q;
    assign cnt_inc = {1'b0, cnt_q} + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        hi_d    = hi_q;
        mid_d   = mid_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        if (acc && (state_q == S_B0 || state_q == S_B1 || state_q == S_B2)) begin
            xor_d = xor_q ^ rx_data;
        end
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
`ifdef IM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_HDR: begin
                if (acc) begin
                    if (rx_data == 8'd0 || int'(rx_data) > CAP) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = rx_data[ADDR_W:0];
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (acc) begin
                    if (rx_data[7:1] != 7'd0) begin
                        state_d = S_ERR;
                    end else begin
                        hi_d    = rx_data[0];
                        state_d = S_B1;
                    end
                end
            end
            S_B1: begin
                if (acc) begin
                    mid_d   = rx_data;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (acc) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = {hi_q, mid_q, rx_data};
                    // Counter wraps to 0 on the final word of a full-capacity load.
                    cnt_d   = cnt_inc[ADDR_W-1:0];
                    if (cnt_inc == n_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            S_CHK: begin
`ifdef IM_LOADER_CHECKSUM_EN
                if (acc) begin
                    state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
                end
`else
                state_d = S_ERR;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the decoded next state.
        rx_ready_d = (state_d == S_HDR) || (state_d == S_B0) || (state_d == S_B1)
                  || (state_d == S_B2) || (state_d == S_CHK);
        cpu_hold_d = rx_ready_d || (state_d == S_ERR);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            hi_q       <= 1'b0;
            mid_q      <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            hi_q       <= hi_d;
            mid_q      <= mid_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign rx_ready = rx_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed plus randomized bench for im_loader against a stream-parsing reference model.
module tb_im_loader;

    localparam int ADDR_W = 5;
    localparam int WORD_W = 17;
    localparam int EW     = ADDR_W + WORD_W;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    im_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]    stim_q[$];
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] wr_q[$];
    bit            exp_ok;
    int            exp_cons;
    int            drops;
    bit            timed_out;

    always @(negedge clk) if (we === 1'b1) wr_q.push_back({waddr, wdata});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Parse the byte stream as the loader protocol describes it.
    task automatic model();
        int n, pos;
        logic [7:0] x, b0, b1, b2;
        exp_q.delete();
        exp_ok = 1'b0;
        x = '0;
        n = int'(stim_q[0]);
        if (n == 0 || n > CAP) begin
            exp_cons = 1;
            return;
        end
        pos = 1;
        for (int k = 0; k < n; k++) begin
            b0 = stim_q[pos];
            if (b0 > 8'd1) begin
                exp_cons = pos + 1;
                return;
            end
            b1 = stim_q[pos+1];
            b2 = stim_q[pos+2];
            x = x ^ b0 ^ b1 ^ b2;
            exp_q.push_back({ADDR_W'(k), b0[0], b1, b2});
            pos += 3;
        end
`ifdef IM_LOADER_CHECKSUM_EN
        exp_cons = pos + 1;
        exp_ok   = (stim_q[pos] == x);
`else
        exp_cons = pos;
        exp_ok   = 1'b1;
`endif
    endtask

    task automatic add_checksum();
`ifdef IM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        int n;
        x = '0;
        n = int'(stim_q[0]);
        for (int i = 1; i <= 3 * n && i < stim_q.size(); i++) x ^= stim_q[i];
        stim_q.push_back(x);
`endif
    endtask

    task automatic gen_stream(input int n);
        stim_q.delete();
        stim_q.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            stim_q.push_back(8'($urandom_range(0, 1)));
            stim_q.push_back(8'($urandom));
            stim_q.push_back(8'($urandom));
        end
        add_checksum();
    endtask

    task automatic pulse_start();
        wr_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // gaps: 0 continuous, 1 alternate valid, 2 random valid.
    task automatic drive(input int cnt, input int gaps, input int start_mid);
        int i, cyc;
        i = 0; cyc = 0; drops = 0; timed_out = 1'b0;
        while (i < cnt && !timed_out) begin
            @(negedge clk);
            start = (cyc == start_mid);
            if (!rx_ready) drops++;
            if ((gaps == 1 && (cyc % 2) == 1) || (gaps == 2 && ($urandom % 3) == 0)) begin
                rx_valid = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data  = stim_q[i];
                if (rx_ready) i++;
            end
            cyc++;
            if (cyc > 4000) timed_out = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        chk("drive_timeout", 32'(timed_out), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
            chk($sformatf("%s_wr%0d", tag, k), 32'(wr_q[k]), 32'(exp_q[k]));
    endtask

    task automatic session(input string tag, input int gaps, input int start_mid);
        int w;
        model();
        pulse_start();
        drive(exp_cons, gaps, start_mid);
        w = 0;
        while (!(done === 1'b1 || error === 1'b1) && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_done"}, 32'(done), 32'(exp_ok));
        chk({tag, "_error"}, 32'(error), 32'(!exp_ok));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_ok));
        chk({tag, "_rdy"}, 32'(rx_ready), 32'd0);
        chk({tag, "_drops"}, 32'(drops), 32'd0);
        check_writes(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"}, 32'(rx_ready), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(wdata), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Two-word directed load, constants cross-checked against the model.
        stim_q = '{8'h02, 8'h00, 8'h0C, 8'h81, 8'h01, 8'h81, 8'h0A};
        add_checksum();
        model();
        chk("t1_exp0", 32'(exp_q[0]), 32'({5'd0, 17'h00C81}));
        chk("t1_exp1", 32'(exp_q[1]), 32'({5'd1, 17'h1810A}));
        session("t1", 0, -1);

        // Bad headers.
        stim_q = '{8'h00};
        session("hdr00", 0, -1);
        stim_q = '{8'h21};
        session("hdr21", 0, -1);

        // Bad first byte after one good word, then a good restart from ERR.
        stim_q = '{8'h02, 8'h00, 8'h0C, 8'h81, 8'h02, 8'h00, 8'h00};
        session("badb0", 0, -1);
        gen_stream(2);
        session("after_err", 0, -1);

        // Alternating valid through a three-word load.
        gen_stream(3);
        session("toggle", 1, -1);

        // Reset after B1 of word 1: only word 0 is written.
        stim_q = '{8'h03, 8'h01, 8'h5A, 8'hC3, 8'h00, 8'h77};
        exp_q.delete();
        exp_q.push_back({5'd0, 1'b1, 8'h5A, 8'hC3});
        pulse_start();
        drive(6, 0, -1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_writes("midrst");
        gen_stream(3);
        session("post_rst", 0, -1);

        // Full capacity and random sessions, some with an ignored start pulse.
        gen_stream(CAP);
        session("full", 2, -1);
        for (int r = 0; r < 6; r++) begin
            gen_stream(int'($urandom_range(1, CAP)));
            session($sformatf("rnd%0d", r), int'($urandom_range(0, 2)), (r % 2 == 1) ? 5 : -1);
        end

`ifdef IM_LOADER_CHECKSUM_EN
        stim_q = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h26};
        session("cs_ok", 0, -1);
        stim_q = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h27};
        session("cs_bad", 0, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
